// File: rtl/jtpopeye_objrom.sv
// Object-ROM fetch responder.
// Watches the renderer's obj_addr, fetches the plane-0 and plane-1 words for
// it from SDRAM one request at a time, and presents both words together.
// If the address moves while a fetch is in flight, the fetch still runs to
// completion (only one request may be outstanding). Its results are then
// discarded and the fetch restarts with the new address.
//
// SDRAM handshake: sdram_req stays high for the whole REQ0/REQ1 state and
// drops the cycle after sdram_ack is sampled. sdram_addr is valid while
// sdram_req is high and holds its value otherwise. The controller pulses
// sdram_rdy for one cycle with sdram_data valid. An ack is only honoured in
// REQx and a rdy only in WAITx; pulses in any other state are ignored.
module jtpopeye_objrom #(
  parameter int            AW       = 22,
  parameter logic [AW-1:0] OBJ_BASE = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [12:0]   obj_addr,
  output logic [15:0]   obj_data0,
  output logic [15:0]   obj_data1,
  output logic          obj_late,
  output logic [AW-1:0] sdram_addr,
  output logic          sdram_req,
  input  logic          sdram_ack,
  input  logic          sdram_rdy,
  input  logic [15:0]   sdram_data
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    WAIT0 = 3'd2,
    REQ1  = 3'd3,
    WAIT1 = 3'd4
  } state_t;

  // state is left as a named signal so checkers can bind to it directly
  state_t      state, state_nx;
  logic [12:0] cur_addr;
  logic [12:0] done_addr;
  logic        done_vld;
  logic        stale;
  logic [15:0] buf0;
  logic        start;
  logic        set_stale;

  // a new fetch is needed when the outputs do not hold the requested address
  assign start     = (state == IDLE) && ((obj_addr != done_addr) || !done_vld);
  // first address change seen during an in-flight fetch
  assign set_stale = (state != IDLE) && !stale && (obj_addr != cur_addr);
  assign sdram_req = (state == REQ0) || (state == REQ1);

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start)     state_nx = REQ0;
      REQ0:    if (sdram_ack) state_nx = WAIT0;
      WAIT0:   if (sdram_rdy) state_nx = REQ1;
      REQ1:    if (sdram_ack) state_nx = WAIT1;
      WAIT1:   if (sdram_rdy) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  // state register, fetch bookkeeping and double-buffered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cur_addr   <= '0;
      done_addr  <= '0;
      done_vld   <= 1'b0;
      stale      <= 1'b0;
      buf0       <= '0;
      obj_data0  <= '0;
      obj_data1  <= '0;
      obj_late   <= 1'b0;
      sdram_addr <= '0;
    end else begin
      state    <= state_nx;
      obj_late <= set_stale;
      if (set_stale) stale <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            cur_addr   <= obj_addr;
            stale      <= 1'b0;
            sdram_addr <= OBJ_BASE + AW'({obj_addr, 1'b0});
          end
        end
        WAIT0: begin
          if (sdram_rdy) begin
            buf0       <= sdram_data;
            sdram_addr <= OBJ_BASE + AW'({cur_addr, 1'b1});
          end
        end
        WAIT1: begin
          if (sdram_rdy && !stale) begin
            obj_data0 <= buf0;
            obj_data1 <= sdram_data;
            done_addr <= cur_addr;
            done_vld  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jtpopeye_objrom.sv
// Bench for jtpopeye_objrom: directed sequence plus randomized latency and
// address runs against an SDRAM responder and a ROM model.
module tb_jtpopeye_objrom;

  localparam int        AW   = 22;
  localparam logic [21:0] BASE = 22'h10000;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] obj_addr;
  logic [15:0] obj_data0, obj_data1;
  logic        obj_late;
  logic [21:0] sdram_addr;
  logic        sdram_req;
  logic        sdram_ack, sdram_rdy;
  logic [15:0] sdram_data;

  jtpopeye_objrom #(.AW(AW), .OBJ_BASE(BASE)) dut (
    .clk(clk), .rst(rst), .obj_addr(obj_addr),
    .obj_data0(obj_data0), .obj_data1(obj_data1), .obj_late(obj_late),
    .sdram_addr(sdram_addr), .sdram_req(sdram_req), .sdram_ack(sdram_ack),
    .sdram_rdy(sdram_rdy), .sdram_data(sdram_data)
  );

  // clock
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ROM contents, indexed by SDRAM word address
  function automatic logic [15:0] rom_word(input logic [21:0] wa);
    logic [21:0] off;
    off = wa - BASE;
    if (off == 22'd0) return 16'hA5A5;
    if (off == 22'd1) return 16'h5A5A;
    return off[15:0] * 16'h9E37 + 16'h1234;
  endfunction

  // expected SDRAM word address for an object address and plane
  function automatic logic [21:0] word_addr(input int a, input int p);
    return 22'(BASE + 22'(a * 2 + p));
  endfunction

  // SDRAM responder controls (written by the main sequence only)
  int a_lat = 1;
  int r_lat = 1;
  bit resp_en = 1'b1;
  int stray_cnt = 0;
  // responder-owned state
  int stray_done = 0;
  int resp_ph = 0;
  int resp_cnt = 0;
  logic [21:0] ack_addr = '0;
  logic [21:0] req_q[$];

  // SDRAM responder: ack A cycles after req is first sampled, rdy R cycles after ack
  initial begin
    sdram_ack = 0; sdram_rdy = 0; sdram_data = '0;
    forever begin
      @(negedge clk);
      sdram_ack = 0; sdram_rdy = 0;
      if (rst) resp_ph = 0;
      else if (stray_cnt != stray_done) begin
        sdram_rdy = 1; sdram_data = 16'hFFFF; stray_done++;
      end else begin
        case (resp_ph)
          0: if (sdram_req && resp_en) begin resp_cnt = a_lat; resp_ph = 1; end
          1: begin
            resp_cnt--;
            if (resp_cnt == 0) begin
              sdram_ack = 1; ack_addr = sdram_addr; req_q.push_back(sdram_addr);
              resp_cnt = r_lat; resp_ph = 2;
            end
          end
          default: begin
            resp_cnt--;
            if (resp_cnt == 0) begin
              sdram_rdy = 1; sdram_data = rom_word(ack_addr); resp_ph = 0;
            end
          end
        endcase
      end
    end
  end

  // output monitors
  int late_cnt = 0;
  int req_cyc = 0;
  bit watch = 0;
  int bad_show = 0;
  always @(negedge clk) begin
    if (obj_late) late_cnt++;
    if (sdram_req) req_cyc++;
    if (watch && obj_data0 == rom_word(word_addr(16'h10, 0)) &&
        obj_data1 == rom_word(word_addr(16'h10, 1))) bad_show++;
  end

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // wait (bounded) for both output words to show the given pair
  task automatic wait_done(input string tag, input int a, input int budget, output int n);
    logic [15:0] e0, e1;
    e0 = rom_word(word_addr(a, 0));
    e1 = rom_word(word_addr(a, 1));
    n = 0;
    while (!(obj_data0 === e0 && obj_data1 === e1) && n < budget) begin
      step(); n++;
    end
    check(tag, {obj_data0, obj_data1}, {e0, e1});
  endtask

  // the last two accepted requests must be plane 0 then plane 1 of address a
  task automatic check_reqs(input string tag, input int a);
    int sz;
    sz = req_q.size();
    check({tag, "_nreq"}, 32'(sz >= 2), 32'd1);
    if (sz >= 2) begin
      check({tag, "_p0"}, 32'(req_q[sz-2]), 32'(word_addr(a, 0)));
      check({tag, "_p1"}, 32'(req_q[sz-1]), 32'(word_addr(a, 1)));
    end
  endtask

  initial begin
    int n, cur, l0, r0, na, tmo;
    rst = 1; obj_addr = '0;
    // reset held two cycles
    step(); step();
    check("rst_data", {obj_data0, obj_data1}, 32'h0);
    check("rst_req", 32'(sdram_req), 0);
    check("rst_addr", 32'(sdram_addr), 0);
    check("rst_late", 32'(obj_late), 0);

    // first fetch after release, address 0
    rst = 0;
    wait_done("boot_data", 0, 50, n);
    check("boot_first_p0", 32'(req_q.size() >= 1 ? req_q[0] : '1), 32'(word_addr(0, 0)));
    check("boot_first_p1", 32'(req_q.size() >= 2 ? req_q[1] : '1), 32'(word_addr(0, 1)));
    step();

    // single fetch with A=2 R=3: 13-cycle latency, no late pulse
    a_lat = 2; r_lat = 3; l0 = late_cnt;
    obj_addr = 13'h1ABC;
    wait_done("single_data", 13'h1ABC, 60, n);
    check("single_latency", 32'(n), 32'd13);
    check_reqs("single", 13'h1ABC);
    check("single_req_p0_abs", 32'(word_addr(13'h1ABC, 0)), 32'h13578);
    check("single_late", 32'(late_cnt - l0), 0);

    // same address held: no SDRAM traffic
    r0 = req_cyc;
    repeat (100) step();
    check("hold_traffic", 32'(req_cyc - r0), 0);
    check("hold_data", {obj_data0, obj_data1},
          {rom_word(word_addr(13'h1ABC, 0)), rom_word(word_addr(13'h1ABC, 1))});

    // address change during WAIT0: one late pulse, stale data never shown
    a_lat = 2; r_lat = 6; l0 = late_cnt;
    watch = 1; obj_addr = 13'h0010;
    tmo = 0;
    while (resp_ph != 2 && tmo < 30) begin step(); tmo++; end
    check("wait0_reached", 32'(tmo < 30), 1);
    obj_addr = 13'h0020;
    wait_done("restart_data", 13'h0020, 100, n);
    step(); step();
    watch = 0;
    check("restart_late", 32'(late_cnt - l0), 1);
    check("restart_no_stale", 32'(bad_show), 0);
    check_reqs("restart", 13'h0020);

    // reset during WAIT1, then stray rdy pulses while the responder is off
    a_lat = 1; r_lat = 4;
    obj_addr = 13'h0155;
    tmo = 0;
    while (!(resp_ph == 2 && ack_addr[0]) && tmo < 40) begin step(); tmo++; end
    check("wait1_reached", 32'(tmo < 40), 1);
    rst = 1; resp_en = 0;
    step();
    check("midrst_req", 32'(sdram_req), 0);
    check("midrst_data", {obj_data0, obj_data1}, 32'h0);
    rst = 0;
    repeat (3) begin stray_cnt++; step(); step(); end
    check("stray_data", {obj_data0, obj_data1}, 32'h0);
    check("stray_late", 32'(obj_late), 0);
    resp_en = 1;
    wait_done("postrst_data", 13'h0155, 60, n);
    check_reqs("postrst", 13'h0155);
    cur = 13'h0155;

    // renderer cadence: new address every 16 cycles, A=1 R=2
    a_lat = 1; r_lat = 2; l0 = late_cnt;
    for (int i = 0; i < 8; i++) begin
      do na = $urandom_range(1, 8191); while (na == cur);
      cur = na;
      obj_addr = 13'(na);
      repeat (16) step();
      check("cadence_data", {obj_data0, obj_data1},
            {rom_word(word_addr(na, 0)), rom_word(word_addr(na, 1))});
    end
    check("cadence_late", 32'(late_cnt - l0), 0);

    // randomized latencies: outputs land exactly 2(A+R)+3 cycles after the change
    for (int i = 0; i < 6; i++) begin
      a_lat = $urandom_range(1, 4);
      r_lat = $urandom_range(1, 4);
      do na = $urandom_range(0, 8191); while (na == cur);
      cur = na;
      obj_addr = 13'(na);
      wait_done("rand_data", na, 80, n);
      check("rand_latency", 32'(n), 32'(2 * (a_lat + r_lat) + 3));
      check_reqs("rand", na);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
